// File: rtl/bidir_switch_pkg.sv
// Shared types and constants for the bidirectional switch sequencer.
//   state_t    : sequencer FSM states
//   sw_ctrl_t  : 2-bit per-switch control word {enable, dir}
//   SW_*       : legal control word encodings (2'b01 is never produced)
//   sw_encode  : maps a command's (en, dir) onto a control word
//   needs_break: true when moving between two enabled words of opposite dir
package bidir_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01,
        ST_BREAK = 2'b10,
        ST_DEAD  = 2'b11
    } state_t;

    typedef logic [1:0] sw_ctrl_t;

    localparam sw_ctrl_t SW_OFF    = 2'b00;
    localparam sw_ctrl_t SW_P1TOP2 = 2'b11;
    localparam sw_ctrl_t SW_P2TOP1 = 2'b10;

    // dir is meaningless for a disabled switch, so it is forced low there
    function automatic sw_ctrl_t sw_encode(input logic en, input logic dir);
        sw_ctrl_t word;
        if (en == 1'b0) begin
            word = SW_OFF;
        end else if (dir == 1'b1) begin
            word = SW_P1TOP2;
        end else begin
            word = SW_P2TOP1;
        end
        return word;
    endfunction

    // A break is only required when a driving switch flips direction;
    // going to or from OFF can never create a contention window.
    function automatic logic needs_break(input sw_ctrl_t cur, input sw_ctrl_t nxt);
        return cur[1] & nxt[1] & (cur[0] ^ nxt[0]);
    endfunction

endpackage

// File: rtl/deadtime_counter.sv
// Down-counter that times the break-to-make gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (wins over enable)
//   load_val   : dead time in cycles
//   enable     : count down one per cycle
//   expire     : high in the cycle the count sits at 1 while enabled
module deadtime_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load, then decrement while enabled, saturating at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (enable && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = enable && (cnt_r == CNT_W'(1));

endmodule

// File: rtl/bidir_switch_seq.sv
// Break-before-make sequencer owning the enable_dir control words of N_SW
// bidirectional switch cells.
//   clk, rst_n   : clock, asynchronous active-low reset
//   cmd_valid    : command offered
//   cmd_ready    : command can be accepted (state IDLE)
//   cmd_idx      : target switch index
//   cmd_en       : 1 = enable switch, 0 = disable
//   cmd_dir      : 1 = port1 drives port2, 0 = port2 drives port1
//   all_off      : synchronous kill of every switch, aborts any command
//   enable_dir_o : registered control words, slot i at [2i+1:2i]
//   busy         : a command is in progress
//   done         : one-cycle pulse on command completion
//   err          : one-cycle pulse on command rejection (bad index)
module bidir_switch_seq
    import bidir_switch_pkg::*;
#(
    parameter int N_SW     = 8,
    parameter int DEAD_CYC = 4,
    parameter int IDX_W    = $clog2(N_SW)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IDX_W-1:0]  cmd_idx,
    input  logic              cmd_en,
    input  logic              cmd_dir,
    input  logic              all_off,
    output logic [2*N_SW-1:0] enable_dir_o,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(DEAD_CYC + 1);

    state_t           state_r;
    sw_ctrl_t         slots_r [N_SW];
    logic [IDX_W-1:0] lat_idx_r;
    sw_ctrl_t         lat_new_r;
    logic             lat_err_r;
    logic             done_r;
    logic             err_r;

    logic [31:0]      cmd_idx_ext_s;
    logic [31:0]      lat_idx_ext_s;
    sw_ctrl_t         cur_s;
    sw_ctrl_t         new_s;
    logic             bad_idx_s;
    logic             brk_s;
    logic             dead_expire_s;
    logic             dead_load_s;
    logic             dead_en_s;

    // Indices are compared at 32 bits so an index field wider than the
    // slot array (possible when IDX_W is overridden) is handled safely.
    assign cmd_idx_ext_s = 32'(cmd_idx);
    assign lat_idx_ext_s = 32'(lat_idx_r);
    assign bad_idx_s     = (cmd_idx_ext_s >= 32'(N_SW));
    assign new_s         = sw_encode(cmd_en, cmd_dir);

    // Current control word of the addressed slot (OFF when out of range)
    always_comb begin
        cur_s = SW_OFF;
        for (int i = 0; i < N_SW; i++) begin
            cur_s = (cmd_idx_ext_s == 32'(i)) ? slots_r[i] : cur_s;
        end
    end

    assign brk_s = needs_break(cur_s, new_s);

    assign dead_load_s = (state_r == ST_BREAK);
    assign dead_en_s   = (state_r == ST_DEAD);

    deadtime_counter #(
        .CNT_W (CNT_W)
    ) u_dead (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dead_load_s),
        .load_val (CNT_W'(DEAD_CYC)),
        .enable   (dead_en_s),
        .expire   (dead_expire_s)
    );

    // Sequencer FSM, slot registers and completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            lat_idx_r <= {IDX_W{1'b0}};
            lat_new_r <= SW_OFF;
            lat_err_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            for (int i = 0; i < N_SW; i++) begin
                slots_r[i] <= SW_OFF;
            end
        end else if (all_off) begin
            // Kill beats everything, including a command offered this cycle
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            for (int i = 0; i < N_SW; i++) begin
                slots_r[i] <= SW_OFF;
            end
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        lat_idx_r <= cmd_idx;
                        lat_new_r <= new_s;
                        lat_err_r <= bad_idx_s;
                        if (!bad_idx_s && brk_s) begin
                            state_r <= ST_BREAK;
                        end else begin
                            state_r <= ST_APPLY;
                        end
                    end
                end
                ST_APPLY: begin
                    if (lat_err_r) begin
                        err_r <= 1'b1;
                    end else begin
                        done_r <= 1'b1;
                        for (int i = 0; i < N_SW; i++) begin
                            if (lat_idx_ext_s == 32'(i)) begin
                                slots_r[i] <= lat_new_r;
                            end
                        end
                    end
                    state_r <= ST_IDLE;
                end
                ST_BREAK: begin
                    for (int i = 0; i < N_SW; i++) begin
                        if (lat_idx_ext_s == 32'(i)) begin
                            slots_r[i] <= SW_OFF;
                        end
                    end
                    state_r <= ST_DEAD;
                end
                ST_DEAD: begin
                    if (dead_expire_s) begin
                        state_r <= ST_APPLY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Flatten slot registers onto the control-word bus
    for (genvar g = 0; g < N_SW; g++) begin : g_slot
        assign enable_dir_o[2*g +: 2] = slots_r[g];
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_bidir_switch_seq.sv
// Directed self-checking bench for bidir_switch_seq (N_SW=8, DEAD_CYC=4,
// IDX_W widened to 4 so out-of-range indices can be driven).
module tb_bidir_switch_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_idx;
    logic        cmd_en;
    logic        cmd_dir;
    logic        all_off;
    logic [15:0] enable_dir_o;
    logic        busy;
    logic        done;
    logic        err;

    int total;
    int bad;

    bidir_switch_seq #(
        .N_SW     (8),
        .DEAD_CYC (4),
        .IDX_W    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_idx      (cmd_idx),
        .cmd_en       (cmd_en),
        .cmd_dir      (cmd_dir),
        .all_off      (all_off),
        .enable_dir_o (enable_dir_o),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command for a single edge; afterwards time is just past the accept edge
    task automatic do_cmd(input logic [3:0] idx, input logic en, input logic dir);
        cmd_valid = 1'b1;
        cmd_idx   = idx;
        cmd_en    = en;
        cmd_dir   = dir;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (enable_dir_o !== 16'h0000) begin bad++; $display("FAIL reset_vec: got %h want %h", enable_dir_o, 16'h0000); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_pulses: got done=%b err=%b want 0 0", done, err); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            total++; if (enable_dir_o !== 16'h0000 || done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
                bad++; $display("FAIL idle_cycle%0d: got vec=%h done=%b err=%b ready=%b want 0000 0 0 1", c, enable_dir_o, done, err, cmd_ready);
            end
        end
    endtask

    task automatic test_enable();
        do_cmd(4'd3, 1'b1, 1'b1);
        total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL enable_busy: got busy=%b ready=%b want 1 0", busy, cmd_ready); end
        total++; if (enable_dir_o !== 16'h0000 || done !== 1'b0) begin bad++; $display("FAIL enable_early: got vec=%h done=%b want 0000 0", enable_dir_o, done); end
        step();
        total++; if (enable_dir_o !== 16'h00C0) begin bad++; $display("FAIL enable_vec: got %h want %h", enable_dir_o, 16'h00C0); end
        total++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin bad++; $display("FAIL enable_done: got done=%b ready=%b want 1 1", done, cmd_ready); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL enable_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_reversal();
        logic [1:0] prev;
        logic [1:0] exp_slot;
        do_cmd(4'd3, 1'b1, 1'b0);
        total++; if (enable_dir_o !== 16'h00C0) begin bad++; $display("FAIL rev_accept_vec: got %h want %h", enable_dir_o, 16'h00C0); end
        prev = enable_dir_o[7:6];
        for (int c = 1; c <= 6; c++) begin
            step();
            exp_slot = (c < 6) ? 2'b00 : 2'b10;
            total++; if (enable_dir_o[7:6] !== exp_slot) begin bad++; $display("FAIL rev_slot3_c%0d: got %b want %b", c, enable_dir_o[7:6], exp_slot); end
            total++; if (done !== (c == 6)) begin bad++; $display("FAIL rev_done_c%0d: got %b want %b", c, done, (c == 6)); end
            total++; if (prev == 2'b11 && enable_dir_o[7:6] == 2'b10) begin bad++; $display("FAIL rev_direct_flip_c%0d: got 11->10 want via 00", c); end
            total++; if (enable_dir_o[5:0] !== 6'b0 || enable_dir_o[15:8] !== 8'b0) begin bad++; $display("FAIL rev_others_c%0d: got %h want only slot3", c, enable_dir_o); end
            prev = enable_dir_o[7:6];
        end
        total++; if (enable_dir_o !== 16'h0080) begin bad++; $display("FAIL rev_final_vec: got %h want %h", enable_dir_o, 16'h0080); end
    endtask

    task automatic test_disable_idem();
        do_cmd(4'd5, 1'b1, 1'b0);
        step();
        total++; if (enable_dir_o !== 16'h0880 || done !== 1'b1) begin bad++; $display("FAIL slot5_on: got vec=%h done=%b want 0880 1", enable_dir_o, done); end
        // dir=1 with en=0 must still give OFF
        do_cmd(4'd5, 1'b0, 1'b1);
        step();
        total++; if (enable_dir_o !== 16'h0080 || done !== 1'b1) begin bad++; $display("FAIL slot5_off: got vec=%h done=%b want 0080 1", enable_dir_o, done); end
        do_cmd(4'd5, 1'b0, 1'b1);
        total++; if (enable_dir_o !== 16'h0080 || done !== 1'b0) begin bad++; $display("FAIL idem_accept: got vec=%h done=%b want 0080 0", enable_dir_o, done); end
        step();
        total++; if (enable_dir_o !== 16'h0080 || done !== 1'b1) begin bad++; $display("FAIL idem_done: got vec=%h done=%b want 0080 1", enable_dir_o, done); end
    endtask

    task automatic test_bad_index();
        do_cmd(4'd9, 1'b1, 1'b1);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL bad9_early_err: got %b want 0", err); end
        step();
        total++; if (err !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL bad9_err: got err=%b done=%b want 1 0", err, done); end
        total++; if (enable_dir_o !== 16'h0080) begin bad++; $display("FAIL bad9_vec: got %h want %h", enable_dir_o, 16'h0080); end
        step();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL bad9_err_pulse: got %b want 0", err); end
        do_cmd(4'd8, 1'b1, 1'b0);
        step();
        total++; if (err !== 1'b1 || done !== 1'b0 || enable_dir_o !== 16'h0080) begin bad++; $display("FAIL bad8: got err=%b done=%b vec=%h want 1 0 0080", err, done, enable_dir_o); end
        do_cmd(4'd7, 1'b1, 1'b1);
        step();
        total++; if (err !== 1'b0 || done !== 1'b1 || enable_dir_o !== 16'hC080) begin bad++; $display("FAIL idx7: got err=%b done=%b vec=%h want 0 1 c080", err, done, enable_dir_o); end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_idx = 4'd0; cmd_en = 1'b1; cmd_dir = 1'b1;
        step();
        // second command is held while the first completes; must not be taken yet
        cmd_idx = 4'd1;
        step();
        total++; if (done !== 1'b1 || enable_dir_o !== 16'hC083 || cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_first: got done=%b vec=%h ready=%b want 1 c083 1", done, enable_dir_o, cmd_ready); end
        step();
        cmd_valid = 1'b0;
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: got done=%b busy=%b want 0 1", done, busy); end
        step();
        total++; if (done !== 1'b1 || enable_dir_o !== 16'hC08F) begin bad++; $display("FAIL b2b_second: got done=%b vec=%h want 1 c08f", done, enable_dir_o); end
    endtask

    task automatic test_kill();
        do_cmd(4'd3, 1'b1, 1'b1);
        step();
        total++; if (enable_dir_o !== 16'hC00F) begin bad++; $display("FAIL kill_break_vec: got %h want %h", enable_dir_o, 16'hC00F); end
        step();
        all_off = 1'b1; cmd_valid = 1'b1; cmd_idx = 4'd2; cmd_en = 1'b1; cmd_dir = 1'b1;
        step();
        all_off = 1'b0; cmd_valid = 1'b0;
        total++; if (enable_dir_o !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL kill_dead: got vec=%h busy=%b done=%b want 0000 0 0", enable_dir_o, busy, done); end
        for (int c = 0; c < 8; c++) begin
            step();
            total++; if (enable_dir_o !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL kill_after_c%0d: got vec=%h done=%b busy=%b want 0000 0 0", c, enable_dir_o, done, busy); end
        end
        all_off = 1'b1; cmd_valid = 1'b1; cmd_idx = 4'd2;
        step();
        all_off = 1'b0; cmd_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_idle_accept: got busy=%b want 0", busy); end
        step();
        total++; if (enable_dir_o !== 16'h0000 || done !== 1'b0) begin bad++; $display("FAIL kill_idle_after: got vec=%h done=%b want 0000 0", enable_dir_o, done); end
    endtask

    task automatic test_async_reset();
        do_cmd(4'd6, 1'b1, 1'b1);
        step();
        total++; if (enable_dir_o !== 16'h3000) begin bad++; $display("FAIL areset_pre_vec: got %h want %h", enable_dir_o, 16'h3000); end
        do_cmd(4'd1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (enable_dir_o !== 16'h0000 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL areset_now: got vec=%h busy=%b ready=%b done=%b want 0000 0 1 0", enable_dir_o, busy, cmd_ready, done);
        end
        step();
        total++; if (enable_dir_o !== 16'h0000 || done !== 1'b0) begin bad++; $display("FAIL areset_hold: got vec=%h done=%b want 0000 0", enable_dir_o, done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_idx   = 4'd0;
        cmd_en    = 1'b0;
        cmd_dir   = 1'b0;
        all_off   = 1'b0;
        test_reset();
        test_enable();
        test_reversal();
        test_disable_idem();
        test_bad_index();
        test_back_to_back();
        test_kill();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bidir_switch_seq.md
# bidir_switch_seq

Sequencer that owns the `enable_dir[1:0]` control word of an array of `N_SW` bidirectional switch cells. Commands arrive over a valid/ready interface. Every direction reversal is break-before-make: the switch is disabled, a programmable dead time elapses, then the new direction is driven. This prevents both ends of a switch from driving the same net at once. It sits between the emulator's configuration logic and the switch fabric, and is the only writer of the switch control words.

## Interface
Parameters:
- `N_SW`, default 8: number of switch cells controlled; range 2..64.
- `DEAD_CYC`, default 4: dead-time cycles between break and make; minimum 1.
- `IDX_W`, default `$clog2(N_SW)`: width of the command index.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high exactly when in IDLE.
- `cmd_idx`  in  IDX_W  target switch index.
- `cmd_en`  in  1  1 = enable the switch, 0 = disable it.
- `cmd_dir`  in  1  1 = port1 drives port2, 0 = port2 drives port1; ignored when `cmd_en`=0.
- `all_off`  in  1  synchronous kill; forces every switch off.
- `enable_dir_o`  out  2*N_SW  registered control words; slot i = bits [2i+1:2i], {enable, dir}.
- `busy`  out  1  a command is in progress (state not IDLE).
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  one-cycle pulse when a command is rejected.

## Operation
- Reset values: all slots 2'b00, `cmd_ready`=1, `busy`=0, `done`=0, `err`=0. State is IDLE.
- Slot encoding: OFF=2'b00, P1TOP2=2'b11, P2TOP1=2'b10. The value 2'b01 is never driven.
- Accept occurs on an edge where `cmd_valid && cmd_ready`. The block latches idx, en and dir at that edge.
- FSM states: IDLE, APPLY, BREAK, DEAD.
- Decision at accept, with cur = current value of slot[idx] and new = {cmd_en, cmd_en & cmd_dir}:
  - idx >= N_SW: go to APPLY with the error flag set. No slot changes; `err` pulses.
  - new == cur, or cur == OFF, or new == OFF: go to APPLY (no break needed).
  - cur enabled and new enabled with a different dir: go to BREAK.
- APPLY: write new to slot[idx], pulse `done` (or `err`), return to IDLE.
- BREAK: write OFF to slot[idx], load the dead counter with DEAD_CYC, go to DEAD.
- DEAD: decrement each cycle. When the counter reaches 1, go to APPLY.
- `all_off` has priority over everything. On the next edge all slots become OFF and the FSM returns to IDLE. An in-flight command is aborted with no `done`. A command offered in the same cycle is not accepted.
- Only slot[idx] of the active command changes; all other slots hold.

## Timing
- Accept at edge k. No-break path: slot updated and `done` high after edge k+1; `cmd_ready` high again after edge k+1. Latency 1.
- Break path: slot = OFF after edge k+1. It stays OFF for DEAD_CYC+1 cycles, then takes the new value after edge k+2+DEAD_CYC, with `done` in that same cycle. Latency 2+DEAD_CYC.
- Back-to-back commands: a new accept can occur on the same edge that `done` is registered-low again, giving one command per 2 cycles at best.
- `cmd_ready` and `busy` are combinational decodes of the state register (`cmd_ready` = !`busy`).
- Reset asserted mid-command: immediate return to reset values, regardless of the clock.

## Structure
- Package `bidir_switch_pkg`: FSM state enum; slot encoding constants SW_OFF, SW_P1TOP2, SW_P2TOP1; the `sw_ctrl_t` 2-bit typedef.
- One sub-module, `deadtime_counter`:
  - inputs: load, load value, enable;
  - output: expire pulse;
  - width `$clog2(DEAD_CYC+1)`.
- The top instantiates no switch cells. `enable_dir_o` slots are wired to the `enable_dir` inputs of the cells one level up.

## Test plan
- Reset then idle: all slots 00, `cmd_ready`=1, no pulses for 20 cycles.
- Enable from OFF: idx=3, en=1, dir=1 → slot3=11 one cycle after accept, `done` pulse, slot2 and slot4 unchanged.
- Reversal with DEAD_CYC=4: idx=3 currently 11, command dir=0 → slot3=00 for exactly 5 cycles, then 10; `done` at latency 6. A monitor checks that slot3 never goes 11→10 directly.
- Disable and idempotent: slot5=10 with en=0 → 00 at latency 1. Repeating the identical command → `done` at latency 1 with no glitch.
- Bad index with N_SW=8: idx=9 (IDX_W widened in the bench) → `err` pulse, no slot change, `done` stays 0.
- Kill mid-dead-time: `all_off` during DEAD → all slots 00 next cycle, IDLE, no `done`. A `cmd_valid` offered in that cycle is not accepted.
